axil_sram: RTL

// - AXI4-Lite slave SRAM. Sits directly downstream of the core's fetch and LSU

---
 rtl/axil_pkg.sv | 35 +++
 rtl/axil_sram_lfsr8.sv | 25 ++
 rtl/axil_sram.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite SRAM slave.
package axil_pkg;

  localparam int unsigned LAT_W = 3;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_e;

  // Replace the bytes of old_word selected by strb with those of new_word.
  function automatic logic [31:0] merge_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_sram_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running; a zero seed becomes 8'h01.
module lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Shift left every cycle, feedback from taps 8,6,5,4.
  always_comb begin
    q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  // State register; reload the seed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= (seed == 8'h00) ? 8'h01 : seed;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/axil_sram.sv
// AXI4-Lite slave SRAM with independent read/write channels and
// programmable or LFSR-random response latency.
module axil_sram
  import axil_pkg::*;
#(
  parameter int unsigned             ADDR_W     = 32,
  parameter int unsigned             DATA_W     = 32,
  parameter logic [ADDR_W-1:0]       BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned             DEPTH      = 4096,
  parameter bit                      LAT_RANDOM = 1'b1,
  parameter int unsigned             FIXED_LAT  = 2,
  parameter logic [7:0]              LFSR_SEED  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int unsigned       IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);

  logic [7:0]       lfsr;
  logic [LAT_W-1:0] rd_lat;
  logic [LAT_W-1:0] wr_lat;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  assign rd_lat = LAT_RANDOM ? lfsr[2:0] : LAT_W'(FIXED_LAT);
  assign wr_lat = LAT_RANDOM ? lfsr[5:3] : LAT_W'(FIXED_LAT);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read channel state
  rd_state_e         r_state_q, r_state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [LAT_W-1:0]  rcnt_q, rcnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  resp_e             rresp_q, rresp_d;
  logic [ADDR_W-1:0] r_off;
  logic              r_in;
  logic [IDX_W-1:0]  r_idx;

  // Write channel state
  wr_state_e         w_state_q, w_state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [LAT_W-1:0]  wcnt_q, wcnt_d;
  resp_e             bresp_q, bresp_d;
  logic [ADDR_W-1:0] w_off;
  logic              w_in;
  logic [IDX_W-1:0]  w_idx;
  logic              mem_we;

  // Address decode: unsigned subtract makes below-base addresses wrap out of range.
  always_comb begin
    r_off = raddr_q - BASE_ADDR;
    r_in  = (r_off < SPAN);
    r_idx = r_off[IDX_W+1:2];
    w_off = waddr_q - BASE_ADDR;
    w_in  = (w_off < SPAN);
    w_idx = w_off[IDX_W+1:2];
  end

  // Read FSM: accept address, count down latency, present response until rready.
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          raddr_d   = araddr;
          rcnt_d    = rd_lat;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          rdata_d   = r_in ? mem_q[r_idx] : '0;
          rresp_d   = r_in ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q - LAT_W'(1);
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Write FSM: AW and W captured independently; latency is sampled on AW
  // capture and the wait starts on the edge that captures the second beat.
  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid && !aw_held_q) begin
          waddr_d   = awaddr;
          wcnt_d    = wr_lat;
          aw_held_d = 1'b1;
        end
        if (wvalid && !w_held_q) begin
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          w_held_d = 1'b1;
        end
        if (aw_held_d && w_held_d) w_state_d = W_WAIT;
      end
      W_WAIT: begin
        if (wcnt_q == '0) begin
          mem_we    = w_in;
          bresp_d   = w_in ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end else begin
          wcnt_d = wcnt_q - LAT_W'(1);
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      wcnt_q    <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      wcnt_q    <= wcnt_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory array, not reset; a same-edge read latch sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[w_idx] <= merge_strb(mem_q[w_idx], wdata_q, wstrb_q);
  end

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = (w_state_q == W_IDLE) && !aw_held_q;
  assign wready  = (w_state_q == W_IDLE) && !w_held_q;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;

endmodule
